// File: rtl/plot_pkg.sv
// Shared constants, FSM state type and round-robin helper for the plot scheduler.
package plot_pkg;

   localparam int unsigned X_W      = 8;
   localparam int unsigned Y_W      = 7;
   localparam int unsigned COLOUR_W = 3;
   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;

   typedef enum logic [0:0] {
      StIdle,
      StDraw
   } state_e;

   // Pointer value that follows a grant to requester idx out of n.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from ptr_i, with wrap.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   gnt_idx_o,
   output logic               valid_o
);

   logic [PTR_W-1:0] idx;

   // Walk the requesters in priority order starting at the pointer; first hit wins.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      valid_o   = 1'b0;
      idx       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((32'(ptr_i) + k) % NUM_REQ);
         if (!valid_o && req_i[idx]) begin
            valid_o    = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/plot_scheduler.sv
// Shares the VGA adapter pixel port between requesters: round-robin grant, then walks the
// granted rectangle one pixel per cycle (row-major), clipping pixels outside the screen.
module plot_scheduler
   import plot_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*X_W-1:0]       req_x,
   input  logic [NUM_REQ*Y_W-1:0]       req_y,
   input  logic [NUM_REQ*X_W-1:0]       req_w,
   input  logic [NUM_REQ*Y_W-1:0]       req_h,
   input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
   output logic [NUM_REQ-1:0]           ack,
   output logic                         done,
   output logic                         busy,
   output logic [X_W-1:0]               x,
   output logic [Y_W-1:0]               y,
   output logic [COLOUR_W-1:0]          colour,
   output logic                         plot
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e                state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;

   // Latched rectangle and walk counters
   logic [X_W-1:0]        x0_q, x0_d, w_q, w_d, cx_q, cx_d;
   logic [Y_W-1:0]        y0_q, y0_d, h_q, h_d, cy_q, cy_d;
   logic [COLOUR_W-1:0]   col_q, col_d;

   // Registered outputs
   logic [NUM_REQ-1:0]    ack_q, ack_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic [X_W-1:0]        x_q, x_d;
   logic [Y_W-1:0]        y_q, y_d;
   logic [COLOUR_W-1:0]   colour_q, colour_d;
   logic                  plot_q, plot_d;

   logic [NUM_REQ-1:0]    gnt;
   logic [PTR_W-1:0]      gnt_idx;
   logic                  gnt_valid;

   logic [X_W-1:0]        sel_x, sel_w;
   logic [Y_W-1:0]        sel_y, sel_h;
   logic [COLOUR_W-1:0]   sel_col;

   // One extra bit so an off-screen sum never wraps back on-screen
   logic [X_W:0]          px_sum;
   logic [Y_W:0]          py_sum;
   logic                  last_col, last_row;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .valid_o   (gnt_valid)
   );

   // One-hot mux of the winner's rectangle fields.
   always_comb begin
      sel_x   = '0;
      sel_y   = '0;
      sel_w   = '0;
      sel_h   = '0;
      sel_col = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_x   |= req_x[i*X_W +: X_W];
            sel_y   |= req_y[i*Y_W +: Y_W];
            sel_w   |= req_w[i*X_W +: X_W];
            sel_h   |= req_h[i*Y_W +: Y_W];
            sel_col |= req_colour[i*COLOUR_W +: COLOUR_W];
         end
      end
   end

   // Current pixel position and end-of-row / end-of-rectangle detection.
   always_comb begin
      px_sum   = {1'b0, x0_q} + {1'b0, cx_q};
      py_sum   = {1'b0, y0_q} + {1'b0, cy_q};
      last_col = (cx_q == w_q - X_W'(1));
      last_row = (cy_q == h_q - Y_W'(1));
   end

   // FSM next state, counter stepping and next output values.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      w_d      = w_q;
      h_d      = h_q;
      col_d    = col_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      ack_d    = '0;
      done_d   = 1'b0;
      busy_d   = 1'b0;
      x_d      = '0;
      y_d      = '0;
      colour_d = '0;
      plot_d   = 1'b0;

      case (state_q)
         StIdle: begin
            if (gnt_valid) begin
               ack_d = gnt;
               ptr_d = PTR_W'(rr_next(32'(gnt_idx), NUM_REQ));
               x0_d  = sel_x;
               y0_d  = sel_y;
               w_d   = sel_w;
               h_d   = sel_h;
               col_d = sel_col;
               cx_d  = '0;
               cy_d  = '0;
               // An empty rectangle completes at once with nothing plotted
               if (sel_w == '0 || sel_h == '0) begin
                  done_d = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  state_d = StDraw;
               end
            end
         end

         StDraw: begin
            busy_d   = 1'b1;
            x_d      = px_sum[X_W-1:0];
            y_d      = py_sum[Y_W-1:0];
            colour_d = col_q;
            plot_d   = (px_sum < (X_W+1)'(SCREEN_W)) && (py_sum < (Y_W+1)'(SCREEN_H));
            if (last_col) begin
               cx_d = '0;
               if (last_row) begin
                  cy_d    = '0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  cy_d = cy_q + Y_W'(1);
               end
            end else begin
               cx_d = cx_q + X_W'(1);
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State, latched fields and registered outputs; reset abandons any rectangle in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         col_q    <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         ack_q    <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         w_q      <= w_d;
         h_q      <= h_d;
         col_q    <= col_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         ack_q    <= ack_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
      end
   end

   assign ack    = ack_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;
   assign plot   = plot_q;

endmodule

// File: tb/tb_plot_scheduler.sv
// Self-checking bench for plot_scheduler: vector table, hand-written corner sequences and
// randomized requests checked against a pixel-level reference model.
module tb_plot_scheduler;
   import plot_pkg::*;

   localparam int unsigned N    = 4;
   localparam int          MAXW = 2000;

   logic                    clock = 1'b0;
   logic                    resetn;
   logic [N-1:0]            req;
   logic [N*X_W-1:0]        req_x, req_w;
   logic [N*Y_W-1:0]        req_y, req_h;
   logic [N*COLOUR_W-1:0]   req_colour;
   logic [N-1:0]            ack;
   logic                    done, busy, plot;
   logic [X_W-1:0]          x;
   logic [Y_W-1:0]          y;
   logic [COLOUR_W-1:0]     colour;

   plot_scheduler #(.NUM_REQ(N)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .req        (req),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_w      (req_w),
      .req_h      (req_h),
      .req_colour (req_colour),
      .ack        (ack),
      .done       (done),
      .busy       (busy),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;
   int ptr   = 0;                       // model round-robin pointer
   int fx[N], fy[N], fw[N], fh[N], fc[N];  // model copy of each requested rectangle

   typedef struct {
      int idx, x0, y0, w, h, c;
      int exp_plots, exp_cycles;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int obs();
      return int'({ack, busy, done, plot, colour, y, x});
   endfunction

   function automatic int pack(int a, int b, int d, int p, int c, int yy, int xx);
      return ((a & 15) << 21) | (b << 20) | (d << 19) | (p << 18) | ((c & 7) << 15)
             | ((yy & 127) << 8) | (xx & 255);
   endfunction

   function automatic int model_grant(int mask);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (ptr + k) % N;
         if (((mask >> i) & 1) != 0) return i;
      end
      return -1;
   endfunction

   task automatic set_rect(input int i, input int x0, input int y0, input int w, input int h,
                           input int c);
      fx[i] = x0; fy[i] = y0; fw[i] = w; fh[i] = h; fc[i] = c;
      req_x[i*X_W +: X_W]                = X_W'(x0);
      req_y[i*Y_W +: Y_W]                = Y_W'(y0);
      req_w[i*X_W +: X_W]                = X_W'(w);
      req_h[i*Y_W +: Y_W]                = Y_W'(h);
      req_colour[i*COLOUR_W +: COLOUR_W] = COLOUR_W'(c);
   endtask

   // Garbage on the port fields only; the model copy stays as granted.
   task automatic scramble(input int i);
      req_x[i*X_W +: X_W]                = X_W'($urandom);
      req_y[i*Y_W +: Y_W]                = Y_W'($urandom);
      req_w[i*X_W +: X_W]                = X_W'($urandom);
      req_h[i*Y_W +: Y_W]                = Y_W'($urandom);
      req_colour[i*COLOUR_W +: COLOUR_W] = COLOUR_W'($urandom);
   endtask

   task automatic wait_ack(output int waited);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (ack == '0 && waited < MAXW);
      if (ack == '0) chk("ack_timeout", 0, 1);
   endtask

   // Called in the ack cycle: checks it, then every pixel cycle of requester i's rectangle.
   task automatic walk(input int i, input int late_k, input int late_mask,
                       output int plots, output int cycles);
      int zero, total;
      zero   = (fw[i] == 0 || fh[i] == 0) ? 1 : 0;
      total  = fw[i] * fh[i];
      plots  = 0;
      cycles = 0;
      chk("ack_cycle", obs(), pack(1 << i, 1 - zero, zero, 0, 0, 0, 0));
      for (int k = 0; k < total; k++) begin
         int ex, ey, p;
         tick();
         ex = fx[i] + k % fw[i];
         ey = fy[i] + k / fw[i];
         p  = (ex < int'(SCREEN_W) && ey < int'(SCREEN_H)) ? 1 : 0;
         chk("pixel", obs(), pack(0, 1, (k == total - 1) ? 1 : 0, p, fc[i], ey, ex));
         plots  += p;
         cycles++;
         if (k == late_k) req = req | N'(late_mask);
      end
   endtask

   // Serve the requesters in mask; each later grant must follow the previous one directly.
   task automatic serve_mask(input int mask, input int n_grants, input bit keep,
                             output int plots, output int cycles);
      int g, waited, wi;
      g = 0; plots = 0; cycles = 0;
      req = N'(mask);
      while (g < n_grants && mask != 0) begin
         wi = model_grant(mask);
         wait_ack(waited);
         if (ack == '0) break;
         chk("grant", int'(ack), 1 << wi);
         if (g > 0) chk("b2b_latency", waited, 1);
         ptr = (wi + 1) % N;
         if (!keep) begin
            mask  &= ~(1 << wi);
            req[wi] = 1'b0;
            scramble(wi);
         end
         walk(wi, -1, 0, plots, cycles);
         g++;
      end
      req = '0;
   endtask

   initial begin
      vec_t vecs[7];
      int   p, c, wt;

      vecs[0] = '{1, 10, 20, 3, 2, 5, 6, 6};
      vecs[1] = '{0, 158, 118, 4, 3, 2, 4, 12};
      vecs[2] = '{2, 5, 5, 0, 5, 3, 0, 0};
      vecs[3] = '{3, 159, 119, 1, 1, 7, 1, 1};
      vecs[4] = '{0, 160, 10, 2, 2, 1, 0, 4};
      vecs[5] = '{1, 0, 0, 1, 3, 2, 3, 3};
      vecs[6] = '{2, 255, 127, 2, 2, 6, 0, 4};

      resetn = 1'b0;
      req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
      #3;
      chk("reset_state", obs(), 0);
      tick();
      resetn = 1'b1;

      // Round robin with every requester held, 1x1 rectangles
      for (int i = 0; i < N; i++) set_rect(i, 2 * i, i, 1, 1, i + 1);
      serve_mask(4'b1111, 5, 1'b1, p, c);
      tick();
      chk("rr_idle", obs(), 0);

      // Vector table
      foreach (vecs[v]) begin
         set_rect(vecs[v].idx, vecs[v].x0, vecs[v].y0, vecs[v].w, vecs[v].h, vecs[v].c);
         serve_mask(1 << vecs[v].idx, 1, 1'b0, p, c);
         chk("vec_plots", p, vecs[v].exp_plots);
         chk("vec_cycles", c, vecs[v].exp_cycles);
         tick();
         chk("vec_idle", obs(), 0);
      end

      // Request raised during a draw waits until the rectangle is done
      set_rect(0, 40, 50, 3, 2, 1);
      set_rect(3, 7, 8, 1, 1, 4);
      ptr = 0;
      req = 4'b0001;
      wait_ack(wt);
      chk("late_first_grant", int'(ack), 1);
      ptr = 1;
      req[0] = 1'b0;
      walk(0, 1, 8, p, c);
      wait_ack(wt);
      chk("late_grant", int'(ack), 8);
      chk("late_latency", wt, 1);
      ptr = 0;
      req[3] = 1'b0;
      walk(3, -1, 0, p, c);
      tick();
      chk("late_idle", obs(), 0);

      // Zero-size rectangle followed directly by the next requester
      set_rect(2, 5, 5, 0, 5, 3);
      set_rect(3, 1, 1, 1, 1, 5);
      serve_mask(4'b1100, 2, 1'b0, p, c);
      tick();
      chk("zero_idle", obs(), 0);

      // Randomized mixes against the model
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < N; i++)
            set_rect(i, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 6),
                     $urandom_range(0, 5), $urandom_range(0, 7));
         serve_mask($urandom_range(1, 15), N, 1'b0, p, c);
         tick();
         chk("rand_idle", obs(), 0);
      end

      // Reset in the middle of a 10x10 draw; pointer must restart at requester 0
      set_rect(1, 20, 30, 10, 10, 6);
      set_rect(3, 5, 5, 1, 1, 2);
      req = 4'b0010;
      wait_ack(wt);
      chk("rst_first_grant", int'(ack), 2);
      req[3] = 1'b1;
      for (int k = 0; k < 37; k++) tick();
      #1;
      resetn = 1'b0;
      #1;
      chk("rst_async_clear", obs(), 0);
      tick();
      chk("rst_held", obs(), 0);
      resetn = 1'b1;
      ptr = 0;
      serve_mask(4'b1010, 2, 1'b0, p, c);
      tick();
      chk("rst_final_idle", obs(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/plot_scheduler.md
Name: plot_scheduler

Overview:
- Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between several drawing requesters, e.g. GUI key highlights and a waveform/status panel.
- Each requester asks for a solid rectangle fill.
- The block arbitrates round-robin, latches the winner's rectangle and walks it one pixel per cycle at 160x120 resolution.
- Off-screen pixels are clipped.

Parameters:
NUM_REQ, 4, number of requesters
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COLOUR_W, 3, colour width (1 bit per channel)
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels

Ports:
clock  input  1  system clock (CLOCK_50 domain)
resetn  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester fill request, level
req_x  input  NUM_REQ*X_W  packed rectangle left x, requester i at [i*X_W +: X_W]
req_y  input  NUM_REQ*Y_W  packed rectangle top y
req_w  input  NUM_REQ*X_W  packed rectangle width in pixels
req_h  input  NUM_REQ*Y_W  packed rectangle height in pixels
req_colour  input  NUM_REQ*COLOUR_W  packed fill colour
ack  output  NUM_REQ  one-hot, 1-cycle pulse when the requester's fields are latched
done  output  1  1-cycle pulse on the last pixel cycle of a rectangle
busy  output  1  high while a rectangle is latched and not finished
x  output  X_W  pixel x to the adapter
y  output  Y_W  pixel y to the adapter
colour  output  COLOUR_W  pixel colour to the adapter
plot  output  1  pixel write enable to the adapter

Behaviour:
- Reset (async, resetn=0) forces all outputs to 0 immediately: ack, done, busy, x, y, colour, plot.
  - State goes to IDLE; round-robin pointer goes to 0.
  - Reset mid-draw abandons the rectangle without ack or done.
- All outputs are registered.
- State IDLE, when any req bit is set:
  - Grant the first set bit searching upward from the pointer, with wrap.
  - In that same cycle, latch x0, y0, w, h and colour of the winner.
  - Pulse ack[winner]; set the pointer to winner+1 mod NUM_REQ.
  - If w==0 or h==0: no plot; pulse done and stay IDLE (busy stays 0).
  - Otherwise set busy=1 and go to DRAW with cx=0, cy=0.
- State IDLE, with no request: plot=0.
- State DRAW, one pixel per cycle, row-major:
  - Outputs: x=x0+cx, y=y0+cy, colour=latched colour.
  - plot=1 unless (x0+cx)>=SCREEN_W or (y0+cy)>=SCREEN_H. Sums are computed at X_W+1 / Y_W+1 bits so there is no wrap.
  - Clipped pixels still consume a cycle with plot=0; x and y carry the truncated value.
  - Stepping: cx increments; at cx==w-1, cx goes to 0 and cy increments.
  - At cx==w-1 and cy==h-1: pulse done on that pixel's output cycle, clear busy on the next cycle, return to IDLE.
- Latency:
  - ack in cycle N means the first pixel appears on x/y/plot in cycle N+1.
  - A w*h rectangle occupies cycles N+1 .. N+w*h.
  - The earliest next ack is cycle N+w*h+1, so back-to-back rectangles have zero gap cycles.
- Handshake:
  - A requester holds req and its fields stable until it sees ack; it may drop req in the ack cycle or later.
  - Fields may change after ack without effect.
  - req held high after ack means a new request, which is rearbitrated.
- Requests arriving during DRAW are ignored until the return to IDLE; no queueing inside the block.
- Simultaneous requests are resolved round-robin only. A requester held continuously is served at least once every NUM_REQ grants.

Decomposition:
- Shared package plot_pkg:
  - SCREEN_W and SCREEN_H constants.
  - X_W, Y_W, COLOUR_W.
  - State enum {IDLE, DRAW}.
- One sub-module rr_arbiter: combinational one-hot grant from req and pointer, NUM_REQ parameter.
- The FSM, counters and clipping stay in plot_scheduler.

Test Plan:
1. Single request: req[1]=1, x=10, y=20, w=3, h=2, colour=3'b101 -> ack[1] in cycle N; plot=1 for cycles N+1..N+6 at (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), colour 101; done in N+6; busy clears N+7.
2. Round-robin: req=4'b1111 held with 1x1 rectangles after reset -> ack order 0,1,2,3,0; each ack one cycle after the previous pixel.
3. Clipping: x=158, y=118, w=4, h=3 -> 12 pixel cycles; plot=1 only for (158,118)(159,118)(158,119)(159,119); done on the 12th cycle.
4. Zero size: w=0, h=5 on req[2] -> ack[2] and done in the same cycle, no plot, busy stays 0, next requester served the following cycle.
5. Reset mid-draw: w=10, h=10, resetn=0 at pixel 37 -> plot, busy and x/y drop to 0 asynchronously. After release with req still high: fresh ack and full 100 pixels from (x0,y0), arbitration starting at requester 0.
6. Late request: req[3] asserted during a DRAW of req[0] -> no ack[3] until the cycle after done, then ack[3].
